// File: rtl/sb_rx_deser_framer_pkg.sv
// ---------------------------------------------------------------------------
// sb_rx_pkg
// Shared types and default constants for the sideband receive deserializer /
// framer slice.
//   sb_rx_state_e : framer state encoding (IDLE, SHIFT, GAP, RESYNC)
//   SB_DATA_W     : default bits per sideband frame
//   SB_MIN_GAP    : default idle cycles required between frames
//   SB_FIFO_DEPTH : default output word buffer depth
// ---------------------------------------------------------------------------
package sb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        GAP    = 2'd2,
        RESYNC = 2'd3
    } sb_rx_state_e;

    localparam int SB_DATA_W     = 64;
    localparam int SB_MIN_GAP    = 32;
    localparam int SB_FIFO_DEPTH = 4;

endpackage : sb_rx_pkg

// File: rtl/sb_rx_deser_framer_if.sv
// ---------------------------------------------------------------------------
// sb_rx_deser_framer_if
// Parallel word output stream of the framer (valid/ready plus occupancy).
//   o_data  : head-of-FIFO word
//   o_valid : FIFO not empty
//   i_ready : consumer accepts o_data (pop when o_valid & i_ready)
//   o_level : current FIFO occupancy
// master modport = framer side, slave modport = consumer side.
// ---------------------------------------------------------------------------
interface sb_rx_deser_framer_if
    import sb_rx_pkg::*;
#(
    parameter int DATA_W     = SB_DATA_W,
    parameter int FIFO_DEPTH = SB_FIFO_DEPTH
) ();

    logic [DATA_W-1:0]             o_data;
    logic                          o_valid;
    logic                          i_ready;
    logic [$clog2(FIFO_DEPTH):0]   o_level;

    modport master (
        output o_data,
        output o_valid,
        output o_level,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_level,
        output i_ready
    );

endinterface : sb_rx_deser_framer_if

// File: rtl/sb_rx_deser_framer_fifo.sv
// ---------------------------------------------------------------------------
// sb_rx_sync_fifo
// Single-clock word buffer between the framer and the consumer.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_push_data : write request and word
//   i_pop          : read request (ignored while empty)
//   o_pop_data     : head word, forced to zero while empty
//   o_full, o_empty, o_level : occupancy status
// A push while full is dropped unless a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module sb_rx_sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_push_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_pop_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic              do_push,  do_pop;

    assign o_full     = (level_q == LVL_W'(DEPTH));
    assign o_empty    = (level_q == '0);
    assign o_level    = level_q;
    assign o_pop_data = o_empty ? '0 : mem_q[rd_ptr_q];

    // Pointers are power-of-two wide, so natural overflow gives the wrap.
    // A full FIFO still accepts a push when the head is leaving that cycle.
    always_comb begin
        do_pop   = i_pop & ~o_empty;
        do_push  = i_push & (~o_full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule : sb_rx_sync_fifo

// File: rtl/sb_rx_deser_framer.sv
// ---------------------------------------------------------------------------
// sb_rx_deser_framer
// Deserializes a qualified sideband bit stream into DATA_W-bit frames,
// enforces frame length and inter-frame gap, and buffers good words.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_ser_data/i_ser_valid: serial bit and its qualifier, first bit -> MSB
//   out (master)          : o_data/o_valid/i_ready/o_level word stream
//   o_err_short           : frame ended before DATA_W bits
//   o_err_long            : more than DATA_W consecutive valid bits
//   o_err_gap             : new frame started before MIN_GAP idle cycles
//   o_overflow            : good word dropped because the FIFO was full
// Error pulses are registered, one cycle after the offending input cycle.
// ---------------------------------------------------------------------------
module sb_rx_deser_framer
    import sb_rx_pkg::*;
#(
    parameter int DATA_W     = SB_DATA_W,
    parameter int FIFO_DEPTH = SB_FIFO_DEPTH,
    parameter int MIN_GAP    = SB_MIN_GAP
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_ser_data,
    input  logic                   i_ser_valid,
    sb_rx_deser_framer_if.master   out,
    output logic                   o_err_short,
    output logic                   o_err_long,
    output logic                   o_err_gap,
    output logic                   o_overflow
);

    localparam int BIT_CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_CNT_W = $clog2(MIN_GAP + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_FULL = BIT_CNT_W'(DATA_W);
    localparam logic [GAP_CNT_W-1:0] GAP_DONE = GAP_CNT_W'(MIN_GAP);

    sb_rx_state_e          state_q,     state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [GAP_CNT_W-1:0]  gap_cnt_q,   gap_cnt_d;
    logic [DATA_W-1:0]     sr_q,        sr_d;
    logic                  err_short_q, err_short_d;
    logic                  err_long_q,  err_long_d;
    logic                  err_gap_q,   err_gap_d;
    logic                  overflow_q,  overflow_d;
    logic [GAP_CNT_W-1:0]  gap_inc;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Framer next-state logic. Idle cycles are counted in both GAP and
    // RESYNC; the cycle that ends a frame already counts as the first idle
    // cycle, so exactly MIN_GAP idle cycles separate accepted frames.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sr_d        = sr_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        err_gap_d   = 1'b0;
        push        = 1'b0;
        gap_inc     = (gap_cnt_q == GAP_DONE) ? gap_cnt_q
                                              : gap_cnt_q + GAP_CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (i_ser_valid) begin
                    sr_d      = DATA_W'(i_ser_data);
                    bit_cnt_d = BIT_CNT_W'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (i_ser_valid) begin
                    if (bit_cnt_q == BIT_FULL) begin
                        err_long_d = 1'b1;
                        gap_cnt_d  = '0;
                        bit_cnt_d  = '0;
                        state_d    = RESYNC;
                    end else begin
                        sr_d      = {sr_q[DATA_W-2:0], i_ser_data};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end else begin
                    gap_cnt_d = GAP_CNT_W'(1);
                    bit_cnt_d = '0;
                    if (bit_cnt_q == BIT_FULL) begin
                        push    = 1'b1;
                        state_d = (MIN_GAP <= 1) ? IDLE : GAP;
                    end else begin
                        err_short_d = 1'b1;
                        state_d     = (MIN_GAP <= 1) ? IDLE : RESYNC;
                    end
                end
            end
            GAP: begin
                if (i_ser_valid) begin
                    err_gap_d = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = RESYNC;
                end else begin
                    gap_cnt_d = gap_inc;
                    if (gap_inc == GAP_DONE) begin
                        state_d = IDLE;
                    end
                end
            end
            RESYNC: begin
                if (i_ser_valid) begin
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_inc;
                    if (gap_inc == GAP_DONE) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = RESYNC;
                gap_cnt_d = '0;
            end
        endcase
        overflow_d = push & fifo_full & ~out.i_ready;
    end

    // Framer registers and registered error pulses. Reset lands in RESYNC
    // so a full idle gap is needed before the first frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= RESYNC;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            sr_q        <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_gap_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            sr_q        <= sr_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_gap_q   <= err_gap_d;
            overflow_q  <= overflow_d;
        end
    end

    sb_rx_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_push_data (sr_q),
        .i_pop       (out.i_ready),
        .o_pop_data  (out.o_data),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_level     (out.o_level)
    );

    assign out.o_valid = ~fifo_empty;
    assign o_err_short = err_short_q;
    assign o_err_long  = err_long_q;
    assign o_err_gap   = err_gap_q;
    assign o_overflow  = overflow_q;

endmodule : sb_rx_deser_framer

// File: tb/tb_sb_rx_deser_framer.sv
// ---------------------------------------------------------------------------
// tb_sb_rx_deser_framer
// Directed bench for sb_rx_deser_framer with default parameters
// (DATA_W=64, FIFO_DEPTH=4, MIN_GAP=32). Inputs change 1 time unit after
// the rising edge; outputs are compared at the same point.
// ---------------------------------------------------------------------------
module tb_sb_rx_deser_framer;
    import sb_rx_pkg::*;

    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int MIN_GAP    = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic ser_data;
    logic ser_valid;
    logic err_short, err_long, err_gap, overflow;

    int vectors     = 0;
    int miscompares = 0;
    int cnt_short   = 0;
    int cnt_long    = 0;
    int cnt_gap     = 0;
    int cnt_ovf     = 0;

    always #5 clk = ~clk;

    sb_rx_deser_framer_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) out_if ();

    sb_rx_deser_framer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MIN_GAP    (MIN_GAP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ser_data  (ser_data),
        .i_ser_valid (ser_valid),
        .out         (out_if),
        .o_err_short (err_short),
        .o_err_long  (err_long),
        .o_err_gap   (err_gap),
        .o_overflow  (overflow)
    );

    // Tally every error pulse so that "exactly once" can be checked later.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_short) cnt_short++;
            if (err_long)  cnt_long++;
            if (err_gap)   cnt_gap++;
            if (overflow)  cnt_ovf++;
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] word_of(input int i);
        return {8'(i), 24'hBEEF00, 8'(i * 7), 24'h5A5A5A};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic data, input logic ready);
        ser_valid      = valid;
        ser_data       = data;
        out_if.i_ready = ready;
        tick();
    endtask

    task automatic send_bits(input logic [127:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b1, val[i], 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        ser_valid      = 1'b0;
        ser_data       = 1'b0;
        out_if.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", out_if.o_valid, 0);
        checkOutput("rst_level", out_if.o_level, 0);
        checkOutput("rst_data",  out_if.o_data,  0);
        checkOutput("rst_errs",  {err_short, err_long, err_gap, overflow}, 0);
        rst_n = 1'b1;
        idle(MIN_GAP);

        // Basic frame and two-cycle latency
        send_bits(64'hA5A5_0000_FFFF_1234, 64);
        checkOutput("lat_not_yet", out_if.o_valid, 0);
        idle(1);
        checkOutput("f1_valid", out_if.o_valid, 1);
        checkOutput("f1_data",  out_if.o_data,  64'hA5A5_0000_FFFF_1234);
        checkOutput("f1_level", out_if.o_level, 1);
        pop_one();
        checkOutput("f1_popped", out_if.o_valid, 0);
        idle(30);

        // Short frame
        send_bits(64'h00_1234_5678, 40);
        idle(1);
        checkOutput("short_pulse", err_short, 1);
        idle(1);
        checkOutput("short_end",   err_short, 0);
        checkOutput("short_nopush", out_if.o_level, 0);
        idle(30);
        send_bits(64'h0123_4567_89AB_CDEF, 64);
        idle(1);
        checkOutput("f2_valid", out_if.o_valid, 1);
        checkOutput("f2_data",  out_if.o_data,  64'h0123_4567_89AB_CDEF);
        checkOutput("short_once", cnt_short, 1);
        pop_one();
        idle(30);

        // Long burst, then RESYNC needs a full gap after the burst
        send_bits(128'h1_F0F0_1111_2222_3333, 65);
        checkOutput("long_pulse", err_long, 1);
        send_bits(128'h15, 5);
        checkOutput("long_end",    err_long, 0);
        checkOutput("long_nopush", out_if.o_level, 0);
        idle(31);
        send_bits(64'hDEAD_BEEF_DEAD_BEEF, 64);
        idle(32);
        checkOutput("resync_drop", out_if.o_level, 0);
        checkOutput("long_once",   cnt_long, 1);
        send_bits(64'h1357_9BDF_2468_ACE0, 64);
        idle(1);
        checkOutput("f3_data", out_if.o_data, 64'h1357_9BDF_2468_ACE0);
        pop_one();
        idle(30);

        // Gap violation
        send_bits(64'h4444_5555_6666_7777, 64);
        idle(10);
        send_bits(64'h8888_9999_AAAA_BBBB, 64);
        checkOutput("gap_pulse", cnt_gap, 1);
        checkOutput("gap_level", out_if.o_level, 1);
        checkOutput("gap_data",  out_if.o_data, 64'h4444_5555_6666_7777);
        idle(32);
        checkOutput("gap_dropped", out_if.o_level, 1);
        checkOutput("gap_no_more", {cnt_gap[7:0], cnt_short[7:0]}, 16'h0101);
        pop_one();
        checkOutput("gap_popped", out_if.o_level, 0);
        idle(31);

        // Overflow with the consumer stalled
        for (int w = 1; w <= 4; w++) begin
            send_bits(word_of(w), 64);
            idle(32);
        end
        checkOutput("full_level", out_if.o_level, 4);
        checkOutput("full_head",  out_if.o_data,  word_of(1));
        send_bits(word_of(5), 64);
        idle(1);
        checkOutput("ovf_pulse", overflow, 1);
        checkOutput("ovf_level", out_if.o_level, 4);
        idle(1);
        checkOutput("ovf_end",    overflow, 0);
        checkOutput("ovf_stable", out_if.o_data, word_of(1));
        idle(30);
        // Push and pop together while full
        send_bits(word_of(6), 64);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pp_level", out_if.o_level, 4);
        checkOutput("pp_noovf", overflow, 0);
        for (int w = 2; w <= 4; w++) begin
            checkOutput($sformatf("pop_w%0d", w), out_if.o_data, word_of(w));
            pop_one();
        end
        checkOutput("pop_w6", out_if.o_data, word_of(6));
        pop_one();
        checkOutput("drained", out_if.o_level, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pop_empty_level", out_if.o_level, 0);
        checkOutput("pop_empty_valid", out_if.o_valid, 0);
        checkOutput("ovf_once", cnt_ovf, 1);
        idle(25);

        // Reset in the middle of a frame with two words buffered
        send_bits(word_of(7), 64);
        idle(32);
        send_bits(word_of(8), 64);
        idle(32);
        checkOutput("pre_rst_level", out_if.o_level, 2);
        send_bits(word_of(9), 30);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", out_if.o_valid, 0);
        checkOutput("async_rst_level", out_if.o_level, 0);
        checkOutput("async_rst_data",  out_if.o_data,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        send_bits(word_of(10), 64);
        idle(1);
        checkOutput("post_rst_drop", out_if.o_valid, 0);
        idle(31);
        send_bits(word_of(11), 64);
        idle(1);
        checkOutput("post_rst_valid", out_if.o_valid, 1);
        checkOutput("post_rst_data",  out_if.o_data,  word_of(11));
        checkOutput("err_totals", {cnt_short[7:0], cnt_long[7:0], cnt_gap[7:0], cnt_ovf[7:0]},
                    32'h0101_0101);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sb_rx_deser_framer
